systolic_west_feeder: RTL and testbench

// - West-edge input feeder for the systolic array. It sits directly upstream of the

---
 rtl/systolic_west_feeder_if.sv | 41 ++++
 rtl/systolic_west_feeder.sv | 114 +++++++++++
 tb/tb_systolic_west_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_west_feeder_if.sv
// Bus bundle between the activation source (master) and the west-edge feeder (slave).
// beat_cnt is present only when WEST_FEEDER_BEAT_CNT_EN is defined.
interface systolic_west_feeder_if #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16
);
  // Valid/ready: a beat transfers at a posedge where in_valid && in_ready; in_data,
  // in_last and in_switch are meaningful only then, and in_ready never looks at in_valid.
  logic [ROWS*DATA_WIDTH-1:0] in_data;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_switch;
  logic                       in_ready;
  logic [ROWS*DATA_WIDTH-1:0] out_input;
  logic [ROWS-1:0]            out_valid;
  logic [ROWS-1:0]            out_switch;
  logic                       busy;
  logic                       done;
  logic [1:0]                 dbg_state;
`ifdef WEST_FEEDER_BEAT_CNT_EN
  logic [15:0]                beat_cnt;

  modport master (
    output in_data, in_valid, in_last, in_switch,
    input  in_ready, out_input, out_valid, out_switch, busy, done, dbg_state, beat_cnt
  );
  modport slave (
    input  in_data, in_valid, in_last, in_switch,
    output in_ready, out_input, out_valid, out_switch, busy, done, dbg_state, beat_cnt
  );
`else
  modport master (
    output in_data, in_valid, in_last, in_switch,
    input  in_ready, out_input, out_valid, out_switch, busy, done, dbg_state
  );
  modport slave (
    input  in_data, in_valid, in_last, in_switch,
    output in_ready, out_input, out_valid, out_switch, busy, done, dbg_state
  );
`endif
endinterface

// File: rtl/systolic_west_feeder.sv
// West-edge feeder: skews row r by r cycles, tracks end of batch, drains, then pulses done.
// Optional per-batch beat counter enabled by WEST_FEEDER_BEAT_CNT_EN.
module systolic_west_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_west_feeder_if.slave bus
);

  localparam int CNT_W = $clog2(ROWS) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = (ROWS > 1) ? CNT_W'(ROWS - 2) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             accept;

  assign bus.in_ready  = (state_q != DRAIN);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

  // The drain count lines done up with the last beat reaching row ROWS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (!bus.in_last) begin
              state_q <= STREAM;
            end else if (ROWS == 1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] data_q [r+1];
    logic [r:0]            valid_q;
    logic [r:0]            sw_q;

    // Stage 0 takes a bubble (all zero) whenever no beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= r; s++) data_q[s] <= '0;
        valid_q <= '0;
        sw_q    <= '0;
      end else begin
        data_q[0]  <= accept ? bus.in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        valid_q[0] <= accept;
        sw_q[0]    <= accept && bus.in_switch;
        for (int s = 1; s <= r; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
          sw_q[s]    <= sw_q[s-1];
        end
      end
    end

    assign bus.out_input[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
    assign bus.out_valid[r]  = valid_q[r];
    assign bus.out_switch[r] = sw_q[r];
  end

`ifdef WEST_FEEDER_BEAT_CNT_EN
  logic [15:0] beat_cnt_q;

  // A beat accepted in the done cycle already belongs to the next batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (done_q) begin
      beat_cnt_q <= accept ? 16'd1 : 16'd0;
    end else if (accept && beat_cnt_q != 16'hFFFF) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign bus.beat_cnt = beat_cnt_q;
`else
  // No beat counter in this build.
`endif

endmodule

// File: tb/tb_systolic_west_feeder.sv
// Directed bench for systolic_west_feeder (ROWS=4, DATA_WIDTH=16); beat counter
// scenario runs only when WEST_FEEDER_BEAT_CNT_EN is defined.
module tb_systolic_west_feeder;
  localparam int ROWS = 4;
  localparam int DW   = 16;

  logic clk;
  logic rst;

  systolic_west_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) bus ();

  systolic_west_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Beat table: acceptance edge, data, last, switch tag.
  int                 bt_n;
  int                 bt_edge [16];
  logic [ROWS*DW-1:0] bt_data [16];
  bit                 bt_last [16];
  bit                 bt_sw   [16];

  logic [ROWS*DW-1:0] exp_data;
  logic [ROWS-1:0]    exp_valid;
  logic [ROWS-1:0]    exp_sw;
  logic               exp_done;
  logic               exp_ready;
  logic               exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic add_beat(input int e, input logic [ROWS*DW-1:0] d, input bit last, input bit sw);
    bt_edge[bt_n] = e;
    bt_data[bt_n] = d;
    bt_last[bt_n] = last;
    bt_sw[bt_n]   = sw;
    bt_n++;
  endtask

  // Expected outputs after edge e, from the beat table and the skew/drain rules.
  task automatic model(input int e);
    int start;
    exp_data = '0; exp_valid = '0; exp_sw = '0;
    exp_done = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
    start = -1;
    for (int i = 0; i < bt_n; i++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (bt_edge[i] + r == e) begin
          exp_data[r*DW +: DW] = bt_data[i][r*DW +: DW];
          exp_valid[r] = 1'b1;
          exp_sw[r]    = bt_sw[i];
        end
      end
      if (start < 0) start = bt_edge[i];
      if (bt_last[i]) begin
        if (e == bt_edge[i] + ROWS - 1) exp_done = 1'b1;
        if (e >= bt_edge[i] && e <= bt_edge[i] + ROWS - 2) exp_ready = 1'b0;
        if (e >= start && e <= bt_edge[i] + ROWS - 2) exp_busy = 1'b1;
        start = -1;
      end
    end
  endtask

  // Drive inputs for edge e; non-beat cycles carry garbage that must be ignored.
  task automatic drive(input int e);
    bus.in_valid  = 1'b0;
    bus.in_data   = {$urandom, $urandom};
    bus.in_last   = 1'($urandom_range(0, 1));
    bus.in_switch = 1'($urandom_range(0, 1));
    for (int i = 0; i < bt_n; i++) begin
      if (bt_edge[i] == e) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = bt_data[i];
        bus.in_last   = bt_last[i];
        bus.in_switch = bt_sw[i];
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_switch = 1'b0; bus.in_data = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(2);
    n_checks++;
    if ({bus.out_input, bus.out_valid, bus.out_switch} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%b/%b want 0/0/0", bus.out_input, bus.out_valid, bus.out_switch);
    end
    n_checks++;
    if ({bus.done, bus.busy, bus.in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ctrl got done,busy,ready=%b want 001", {bus.done, bus.busy, bus.in_ready});
    end
    rst = 1'b0;
    idle_cycles(1);
    n_checks++;
    if ({bus.done, bus.busy, bus.in_ready, bus.out_valid} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL post_reset got %b want 0010000", {bus.done, bus.busy, bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_single;
    bt_n = 0;
    add_beat(0, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0);
    for (int e = 0; e <= 4; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if (bus.out_input !== exp_data) begin
        n_fail++; $display("FAIL single_data e=%0d got %h want %h", e, bus.out_input, exp_data);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy} !== {exp_valid, exp_sw, exp_done, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL single_ctrl e=%0d got %b want %b", e,
          {bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy}, {exp_valid, exp_sw, exp_done, exp_ready, exp_busy});
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_stream;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] want;
    int vcnt [ROWS];
    bt_n = 0;
    add_beat(0, {4{16'd10}}, 1'b0, 1'b0);
    add_beat(1, {4{16'd20}}, 1'b0, 1'b0);
    add_beat(2, {4{16'd30}}, 1'b1, 1'b0);
    exp_q = '{16'd10, 16'd20, 16'd30};
    for (int r = 0; r < ROWS; r++) vcnt[r] = 0;
    for (int e = 0; e <= 7; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if (bus.out_input !== exp_data) begin
        n_fail++; $display("FAIL stream_data e=%0d got %h want %h", e, bus.out_input, exp_data);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy} !== {exp_valid, exp_sw, exp_done, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL stream_ctrl e=%0d got %b want %b", e,
          {bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy}, {exp_valid, exp_sw, exp_done, exp_ready, exp_busy});
      end
      for (int r = 0; r < ROWS; r++) if (bus.out_valid[r] === 1'b1) vcnt[r]++;
      if (bus.out_valid[3] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_row3 e=%0d got extra %0d want none", e, bus.out_input[63:48]);
        end else begin
          want = exp_q.pop_front();
          if (bus.out_input[63:48] !== want) begin
            n_fail++; $display("FAIL stream_row3 e=%0d got %0d want %0d", e, bus.out_input[63:48], want);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL stream_row3_left got %0d pending want 0", exp_q.size());
    end
    for (int r = 0; r < ROWS; r++) begin
      n_checks++;
      if (vcnt[r] != 3) begin
        n_fail++; $display("FAIL stream_valid_count row=%0d got %0d want 3", r, vcnt[r]);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_bubble;
    bt_n = 0;
    add_beat(0, {16'h8004, 16'h8003, 16'h8002, 16'h8001}, 1'b0, 1'b0);
    add_beat(2, {16'h7FFF, 16'hFFFE, 16'h1234, 16'hABCD}, 1'b1, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if (bus.out_input !== exp_data) begin
        n_fail++; $display("FAIL bubble_data e=%0d got %h want %h", e, bus.out_input, exp_data);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy} !== {exp_valid, exp_sw, exp_done, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL bubble_ctrl e=%0d got %b want %b", e,
          {bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy}, {exp_valid, exp_sw, exp_done, exp_ready, exp_busy});
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_switch;
    int scnt [ROWS];
    bus.in_valid = 1'b0; bus.in_switch = 1'b1; bus.in_data = '1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_switch !== '0 || bus.out_valid !== '0) begin
        n_fail++; $display("FAIL switch_idle c=%0d got sw=%b v=%b want 0/0", c, bus.out_switch, bus.out_valid);
      end
    end
    bt_n = 0;
    add_beat(0, {4{16'h0101}}, 1'b0, 1'b0);
    add_beat(1, {4{16'h0202}}, 1'b0, 1'b1);
    add_beat(2, {4{16'h0303}}, 1'b1, 1'b0);
    for (int r = 0; r < ROWS; r++) scnt[r] = 0;
    for (int e = 0; e <= 7; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if (bus.out_input !== exp_data) begin
        n_fail++; $display("FAIL switch_data e=%0d got %h want %h", e, bus.out_input, exp_data);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy} !== {exp_valid, exp_sw, exp_done, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL switch_ctrl e=%0d got %b want %b", e,
          {bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy}, {exp_valid, exp_sw, exp_done, exp_ready, exp_busy});
      end
      for (int r = 0; r < ROWS; r++) if (bus.out_switch[r] === 1'b1) scnt[r]++;
    end
    for (int r = 0; r < ROWS; r++) begin
      n_checks++;
      if (scnt[r] != 1) begin
        n_fail++; $display("FAIL switch_pulses row=%0d got %0d want 1", r, scnt[r]);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_drain;
    bt_n = 0;
    add_beat(0, {4{16'h5555}}, 1'b0, 1'b1);
    add_beat(1, {4{16'h6666}}, 1'b1, 1'b0);
    for (int e = 0; e <= 1; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if ({bus.out_input, bus.out_valid, bus.in_ready, bus.busy} !== {exp_data, exp_valid, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL rdrain_pre e=%0d got %h/%b want %h/%b", e,
          bus.out_input, {bus.out_valid, bus.in_ready, bus.busy}, exp_data, {exp_valid, exp_ready, exp_busy});
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_input, bus.out_valid, bus.out_switch, bus.done, bus.busy} !== '0) begin
      n_fail++; $display("FAIL rdrain_async got %h/%b/%b/%b/%b want all 0",
        bus.out_input, bus.out_valid, bus.out_switch, bus.done, bus.busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rdrain_ready_in_reset got %b want 1", bus.in_ready);
    end
    idle_cycles(2);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.done, bus.in_ready, bus.busy, bus.out_valid} !== 7'b0100000) begin
        n_fail++; $display("FAIL rdrain_post c=%0d got %b want 0100000", c, {bus.done, bus.in_ready, bus.busy, bus.out_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    bt_n = 0;
    add_beat(0, {16'h0D, 16'h0C, 16'h0B, 16'h0A}, 1'b1, 1'b0);
    add_beat(4, {16'h1D, 16'h1C, 16'h1B, 16'h1A}, 1'b1, 1'b1);
    for (int e = 0; e <= 8; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      n_checks++;
      if (bus.out_input !== exp_data) begin
        n_fail++; $display("FAIL b2b_data e=%0d got %h want %h", e, bus.out_input, exp_data);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy} !== {exp_valid, exp_sw, exp_done, exp_ready, exp_busy}) begin
        n_fail++; $display("FAIL b2b_ctrl e=%0d got %b want %b", e,
          {bus.out_valid, bus.out_switch, bus.done, bus.in_ready, bus.busy}, {exp_valid, exp_sw, exp_done, exp_ready, exp_busy});
      end
    end
    idle_cycles(2);
  endtask

`ifdef WEST_FEEDER_BEAT_CNT_EN
  task automatic test_beat_cnt;
    logic [15:0] want;
    bt_n = 0;
    for (int i = 0; i < 5; i++) add_beat(i, {4{16'(i + 1)}}, (i == 4), 1'b0);
    for (int e = 0; e <= 9; e++) begin
      drive(e); @(posedge clk); #1; model(e);
      want = (e <= 4) ? 16'(e + 1) : (e <= 7) ? 16'd5 : 16'd0;
      n_checks++;
      if (bus.beat_cnt !== want || bus.done !== exp_done) begin
        n_fail++; $display("FAIL beat_cnt e=%0d got cnt=%0d done=%b want cnt=%0d done=%b",
          e, bus.beat_cnt, bus.done, want, exp_done);
      end
    end
    idle_cycles(2);
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_switch = 1'b0; bus.in_data = '0;
    test_reset();
    test_single();
    test_stream();
    test_bubble();
    test_switch();
    test_reset_drain();
    test_back_to_back();
`ifdef WEST_FEEDER_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
